core_wb_arbiter: RTL

CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

---
 rtl/core_wb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter
// Shares the single register-file write port between the in-order pipeline
// (MEM/WB stage) and the multi-cycle mul/div unit. When both want the port in
// the same cycle, the pipeline wins and the mul/div result is parked in a
// one-entry buffer. The buffer drains on the first cycle the pipeline does not
// write. If the pipeline keeps writing for STARVE_MAX buffered cycles, one
// stall cycle is forced so that the buffer can drain.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   wb_valid_i/wb_rd_i/wb_data_i     pipeline register write
//   md_valid_i/md_rd_i/md_data_i     mul/div result offer
//   md_ready_o                       mul/div result accepted (with md_valid_i)
//   rf_wen_o/rf_waddr_o/rf_wdata_o   register-file write port (combinational)
//   pipe_stall_o                     freeze MEM/WB and earlier stages
//   buf_valid_o/buf_rd_o             pending buffered write, for hazard logic
//
// state | meaning
// IDLE  | buffer empty, mul/div results accepted
// HOLD  | buffer full, waiting for a free write-port cycle
// FORCE | forced drain: pipeline stalled, buffer written
module core_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [63:0] wb_data_i,
  input  logic        md_valid_i,
  input  logic [4:0]  md_rd_i,
  input  logic [63:0] md_data_i,
  output logic        md_ready_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [63:0] rf_wdata_o,
  output logic        pipe_stall_o,
  output logic        buf_valid_o,
  output logic [4:0]  buf_rd_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);
  localparam logic [3:0] CNT_SAT  = 4'd15;

  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  buf_rd;
  logic [63:0] buf_data;
  logic        capture;

  // x0 writes are no writes; an x0 mul/div result is still accepted.
  logic wb_wr, md_acc, md_wr;
  assign wb_wr  = wb_valid_i && (wb_rd_i != 5'd0);
  assign md_acc = md_valid_i && (state == ST_IDLE);
  assign md_wr  = md_acc && (md_rd_i != 5'd0);

  assign md_ready_o   = (state == ST_IDLE);
  assign pipe_stall_o = (state == ST_FORCE);
  assign buf_valid_o  = (state == ST_HOLD) || (state == ST_FORCE);
  assign buf_rd_o     = buf_valid_o ? buf_rd : 5'd0;

  // Write-port select: forced drain, then pipeline, then held buffer,
  // then mul/div write-through.
  always_comb begin
    rf_wen_o   = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 64'd0;
    if (state == ST_FORCE) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = buf_rd;
      rf_wdata_o = buf_data;
    end else if (wb_wr) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = wb_data_i;
    end else if (state == ST_HOLD) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = buf_rd;
      rf_wdata_o = buf_data;
    end else if (md_wr) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = md_rd_i;
      rf_wdata_o = md_data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = 4'd0;
        // Same-rd collision: the pipeline write is younger, so the mul/div
        // result is simply dropped.
        if (md_wr && wb_wr && (md_rd_i != wb_rd_i)) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!wb_wr || (wb_rd_i == buf_rd)) begin
          // Either the buffer drains now, or a younger write to the same
          // register makes it obsolete.
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = (cnt == CNT_SAT) ? CNT_SAT : cnt + 4'd1;
          if (cnt == CNT_LAST) state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_rd   <= 5'd0;
      buf_data <= 64'd0;
    end else if (capture) begin
      buf_rd   <= md_rd_i;
      buf_data <= md_data_i;
    end
  end

endmodule
